// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register file's single write port, plus a per-register
// outstanding-write scoreboard for decode hazard stalls. Optional forwarding: RF_ARB_FORWARD_EN.
module regfile_write_arbiter #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned CNT_W  = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_data,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_data,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_a3,
   output logic [DATA_W-1:0] rf_wd,
   input  logic              issue_valid,
   input  logic [ADDR_W-1:0] issue_addr,
   output logic              issue_ready,
   input  logic [ADDR_W-1:0] check_a1,
   input  logic [ADDR_W-1:0] check_a2,
   output logic              stall,
   output logic              fwd1_hit,
   output logic [DATA_W-1:0] fwd1_data,
   output logic              fwd2_hit,
   output logic [DATA_W-1:0] fwd2_data
);

   localparam int unsigned NumRegs = 2 ** ADDR_W;
   localparam logic [CNT_W-1:0] CntMax = '1;
   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

   logic              ptr_q;
   logic              grant0, grant1, accept;
   logic [ADDR_W-1:0] acc_addr;
   logic [DATA_W-1:0] acc_data;
   logic              issue_fire;
   logic [CNT_W-1:0]  cnt_q [NumRegs];

   // Pointer only breaks ties; a lone valid requester always wins.
   assign grant0     = req0_valid && (!req1_valid || !ptr_q);
   assign grant1     = req1_valid && (!req0_valid ||  ptr_q);
   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign accept     = grant0 || grant1;
   assign acc_addr   = grant1 ? req1_addr : req0_addr;
   assign acc_data   = grant1 ? req1_data : req0_data;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr_q <= 1'b0;
         rf_we <= 1'b0;
         rf_a3 <= '0;
         rf_wd <= '0;
      end else begin
         rf_we <= accept && (acc_addr != '0);
         if (accept) begin
            ptr_q <= grant0;
            rf_a3 <= acc_addr;
            rf_wd <= acc_data;
         end
      end
   end

   // A commit to the same register frees a slot in the cycle it happens.
   assign issue_ready = (issue_addr == '0) || (cnt_q[issue_addr] != CntMax) ||
                        (rf_we && (rf_a3 == issue_addr));
   assign issue_fire  = issue_valid && issue_ready && (issue_addr != '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NumRegs; i++) cnt_q[i] <= '0;
      end else begin
         cnt_q[0] <= '0;
         for (int i = 1; i < NumRegs; i++) begin
            if (issue_fire && (issue_addr == ADDR_W'(i))) begin
               if (!(rf_we && (rf_a3 == ADDR_W'(i)))) cnt_q[i] <= cnt_q[i] + CntOne;
            end else if (rf_we && (rf_a3 == ADDR_W'(i)) && (cnt_q[i] != '0)) begin
               cnt_q[i] <= cnt_q[i] - CntOne;
            end
         end
      end
   end

`ifdef RF_ARB_FORWARD_EN
   // Only the last outstanding write may be forwarded; older ones still stall.
   assign fwd1_hit  = rf_we && (rf_a3 == check_a1) && (check_a1 != '0) &&
                      (cnt_q[check_a1] == CntOne);
   assign fwd2_hit  = rf_we && (rf_a3 == check_a2) && (check_a2 != '0) &&
                      (cnt_q[check_a2] == CntOne);
   assign fwd1_data = rf_wd;
   assign fwd2_data = rf_wd;
   assign stall     = ((cnt_q[check_a1] != '0) && !fwd1_hit) ||
                      ((cnt_q[check_a2] != '0) && !fwd2_hit);
`else
   assign fwd1_hit  = 1'b0;
   assign fwd2_hit  = 1'b0;
   assign fwd1_data = '0;
   assign fwd2_data = '0;
   assign stall     = (cnt_q[check_a1] != '0) || (cnt_q[check_a2] != '0);
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter; expectations follow RF_ARB_FORWARD_EN if defined.
module tb_regfile_write_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [4:0]  req0_addr, req1_addr;
   logic [31:0] req0_data, req1_data;
   logic        rf_we;
   logic [4:0]  rf_a3;
   logic [31:0] rf_wd;
   logic        issue_valid, issue_ready;
   logic [4:0]  issue_addr, check_a1, check_a2;
   logic        stall, fwd1_hit, fwd2_hit;
   logic [31:0] fwd1_data, fwd2_data;

   int n_pass = 0;
   int n_fail = 0;
   int n_total = 0;

`ifdef RF_ARB_FORWARD_EN
   localparam bit Fwd = 1'b1;
`else
   localparam bit Fwd = 1'b0;
`endif

   regfile_write_arbiter dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .req0_valid  (req0_valid),
      .req0_ready  (req0_ready),
      .req0_addr   (req0_addr),
      .req0_data   (req0_data),
      .req1_valid  (req1_valid),
      .req1_ready  (req1_ready),
      .req1_addr   (req1_addr),
      .req1_data   (req1_data),
      .rf_we       (rf_we),
      .rf_a3       (rf_a3),
      .rf_wd       (rf_wd),
      .issue_valid (issue_valid),
      .issue_addr  (issue_addr),
      .issue_ready (issue_ready),
      .check_a1    (check_a1),
      .check_a2    (check_a2),
      .stall       (stall),
      .fwd1_hit    (fwd1_hit),
      .fwd1_data   (fwd1_data),
      .fwd2_hit    (fwd2_hit),
      .fwd2_data   (fwd2_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Inputs change just after a falling edge; checks run 1 time unit later.
   task automatic next_cycle();
      @(negedge clk);
   endtask

   initial begin
      reset_n = 1'b0;
      req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'hA;
      req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'hB;
      issue_valid = 1'b0; issue_addr = 5'd5;
      check_a1 = 5'd3; check_a2 = 5'd4;
      #1;
      chk("reset_rf_we", rf_we, 0);
      chk("reset_rf_a3", rf_a3, 0);
      chk("reset_rf_wd", rf_wd, 0);
      chk("reset_stall", stall, 0);
      chk("reset_issue_ready", issue_ready, 1);
      chk("reset_fwd1_hit", fwd1_hit, 0);
      chk("reset_fwd2_hit", fwd2_hit, 0);
      chk("reset_ptr_req0_ready", req0_ready, 1);
      chk("reset_ptr_req1_ready", req1_ready, 0);

      // Contention: REQ0 first, then REQ1 on the next cycle.
      next_cycle(); reset_n = 1'b1;
      next_cycle(); #1;
      chk("cont_first_we", rf_we, 1);
      chk("cont_first_a3", rf_a3, 3);
      chk("cont_first_wd", rf_wd, 32'hA);
      chk("cont_rr_req0_ready", req0_ready, 0);
      chk("cont_rr_req1_ready", req1_ready, 1);
      next_cycle(); #1;
      chk("cont_second_we", rf_we, 1);
      chk("cont_second_a3", rf_a3, 4);
      chk("cont_second_wd", rf_wd, 32'hB);
      chk("cont_back_req0_ready", req0_ready, 1);
      req0_valid = 1'b0; req1_valid = 1'b0;
      next_cycle(); #1;
      chk("idle_we", rf_we, 0);
      chk("idle_a3_hold", rf_a3, 4);
      chk("idle_wd_hold", rf_wd, 32'hB);

      // Register 0 is accepted but never written or tracked.
      req0_valid = 1'b1; req0_addr = 5'd0; req0_data = 32'hFFFF;
      issue_valid = 1'b1; issue_addr = 5'd0; check_a1 = 5'd0; check_a2 = 5'd0;
      #1;
      chk("r0_req0_ready", req0_ready, 1);
      chk("r0_issue_ready", issue_ready, 1);
      chk("r0_stall", stall, 0);
      next_cycle();
      req0_valid = 1'b0; issue_valid = 1'b0;
      #1;
      chk("r0_rf_we", rf_we, 0);

      // Hazard: fill r5 to the counter limit, then drain with three writes.
      issue_valid = 1'b1; issue_addr = 5'd5;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("haz_issue_ready", issue_ready, 1);
         next_cycle();
      end
      #1;
      chk("haz_issue_full", issue_ready, 0);
      issue_valid = 1'b0; check_a2 = 5'd5;
      #1;
      chk("haz_stall_pending", stall, 1);
      req1_valid = 1'b1; req1_addr = 5'd5; req1_data = 32'h55;
      #1;
      chk("haz_req1_ready", req1_ready, 1);
      next_cycle(); #1;
      chk("haz_w1_we", rf_we, 1);
      chk("haz_w1_a3", rf_a3, 5);
      chk("haz_w1_stall", stall, 1);
      chk("haz_w1_issue_ready", issue_ready, 1);
      next_cycle(); #1;
      chk("haz_cnt2_issue_ready", issue_ready, 1);
      chk("haz_cnt2_stall", stall, 1);
      next_cycle();
      req1_valid = 1'b0;
      #1;
      chk("haz_w3_we", rf_we, 1);
      chk("haz_w3_stall", stall, !Fwd);
      chk("haz_w3_fwd2_hit", fwd2_hit, Fwd);
      next_cycle(); #1;
      chk("haz_release_stall", stall, 0);
      chk("haz_release_we", rf_we, 0);

      // Same-cycle increment and decrement on r7.
      check_a2 = 5'd0;
      issue_valid = 1'b1; issue_addr = 5'd7;
      next_cycle();
      issue_valid = 1'b0;
      req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h77;
      next_cycle();
      req0_valid = 1'b0;
      issue_valid = 1'b1; issue_addr = 5'd7;
      #1;
      chk("incdec_we", rf_we, 1);
      chk("incdec_issue_ready", issue_ready, 1);
      next_cycle();
      issue_valid = 1'b0; check_a1 = 5'd7;
      #1;
      chk("incdec_stall_kept", stall, 1);
      chk("incdec_we_low", rf_we, 0);
      check_a1 = 5'd0;

      // Forwarding window on r9.
      issue_valid = 1'b1; issue_addr = 5'd9;
      next_cycle();
      issue_valid = 1'b0;
      req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h1234;
      next_cycle();
      req0_valid = 1'b0; check_a1 = 5'd9;
      #1;
      chk("fwd_we", rf_we, 1);
      chk("fwd_hit1", fwd1_hit, Fwd);
      chk("fwd_data1", fwd1_data, Fwd ? 32'h1234 : 32'h0);
      chk("fwd_stall", stall, !Fwd);
      next_cycle(); #1;
      chk("fwd_after_stall", stall, 0);
      chk("fwd_after_hit1", fwd1_hit, 0);

      // Asynchronous reset in the middle of a write.
      issue_valid = 1'b1; issue_addr = 5'd10;
      next_cycle(); next_cycle();
      issue_valid = 1'b0; check_a1 = 5'd10; check_a2 = 5'd7;
      req1_valid = 1'b1; req1_addr = 5'd10; req1_data = 32'hAA;
      next_cycle();
      req1_valid = 1'b0;
      #1;
      chk("rst_pre_we", rf_we, 1);
      chk("rst_pre_stall", stall, 1);
      reset_n = 1'b0;
      #1;
      chk("rst_async_we", rf_we, 0);
      chk("rst_async_a3", rf_a3, 0);
      next_cycle();
      reset_n = 1'b1;
      #1;
      chk("rst_stall_cleared", stall, 0);
      chk("rst_issue_ready", issue_ready, 1);
      next_cycle(); #1;
      chk("rst_after_we", rf_we, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

- Shares the register file's single write port between two writeback requesters, such as the ALU/load path and a multi-cycle multiply/divide unit.
- Tracks outstanding writes per architectural register, so decode can stall on read-after-write hazards.
- Sits between the writeback sources and the register file's WE/A3/WD inputs, and feeds the stall input of the decode stage.

## Interface
- DATA_W, 32, register data width
- ADDR_W, 5, register address width (2**ADDR_W registers)
- CNT_W, 2, width of the per-register outstanding-write counter

- CLK  in  1  clock, all state updates on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- REQ0_VALID / REQ1_VALID  in  1  requester n holds a write
- REQ0_READY / REQ1_READY  out  1  requester n's write is accepted this cycle
- REQ0_ADDR / REQ1_ADDR  in  ADDR_W  destination register
- REQ0_DATA / REQ1_DATA  in  DATA_W  write data
- RF_WE  out  1  register file write enable (registered)
- RF_A3  out  ADDR_W  register file write address (registered)
- RF_WD  out  DATA_W  register file write data (registered)
- ISSUE_VALID  in  1  decode issues an instruction that will write ISSUE_ADDR
- ISSUE_ADDR  in  ADDR_W  destination register of the issued instruction
- ISSUE_READY  out  1  scoreboard can record the issue
- CHECK_A1 / CHECK_A2  in  ADDR_W  source registers of the instruction in decode
- STALL  out  1  a source register has an outstanding write
- FWD1_HIT / FWD2_HIT  out  1  forwarded value is valid for operand n (feature-gated)
- FWD1_DATA / FWD2_DATA  out  DATA_W  forwarded value for operand n (feature-gated)

## Operation
- **Arbitration**
  - Round-robin priority over the two requesters. A 1-bit pointer names the preferred requester and flips after every grant.
  - At most one REQn_READY per cycle. REQn_READY = REQn_VALID AND granted. Acceptance occurs on a cycle where VALID and READY are both high.
  - REQn_READY is combinational from the VALID inputs and the pointer.
  - The output stage never back-pressures, so one request is accepted every cycle whenever any VALID is high.
- **Output stage**
  - The accepted address and data are registered into RF_A3/RF_WD.
  - RF_WE is set when the accepted ADDR != 0.
  - When nothing is accepted, RF_WE is 0 and RF_A3/RF_WD hold their previous values.
  - Writes to register 0 are accepted and then dropped: RF_WE stays 0 and no counter changes.
- **Scoreboard**
  - One CNT_W-bit counter per register, excluding register 0, whose counter is hardwired to 0.
  - Issue with ISSUE_VALID&&ISSUE_READY and ISSUE_ADDR != 0 increments the counter.
  - A cycle with RF_WE=1 decrements the counter of RF_A3 at the end of that cycle, which is the same edge on which the register file commits.
  - Simultaneous increment and decrement of the same register leaves the counter unchanged.
  - ISSUE_READY = 0 when the counter of ISSUE_ADDR is at its maximum (2**CNT_W-1) and no decrement of that register occurs this cycle. ISSUE_READY is 1 for ISSUE_ADDR = 0.
  - STALL = (cnt[CHECK_A1] != 0) OR (cnt[CHECK_A2] != 0). STALL is combinational and never asserted for register 0.
- Counter underflow (a decrement with the counter at 0) is a protocol error. The counter saturates at 0.

## Timing
- **Reset values**
  - RF_WE=0, RF_A3=0, RF_WD=0.
  - All counters 0, STALL=0, ISSUE_READY=1.
  - Pointer prefers REQ0, FWDn_HIT=0.
- Reset assertion mid-operation discards any in-flight write immediately; RF_WE drops asynchronously.
- **Latency**
  - Request accepted at edge k.
  - RF_WE high during cycle k..k+1.
  - Register file commits at edge k+1.
  - Counter decremented at edge k+1.
  - The stall releases in cycle k+1..k+2.
- **Both VALID every cycle:** grants alternate 0,1,0,1 starting from the pointer value. Requester throughput is 1/2 each.
- **Single VALID:** that requester is granted every cycle regardless of the pointer. The pointer still flips away from the granted requester.

## Configuration
- **`RF_ARB_FORWARD_EN` defined:**
  - FWDn_HIT=1 when RF_WE=1, RF_A3==CHECK_An (nonzero), and cnt[CHECK_An]==1. FWDn_DATA=RF_WD.
  - A forwarded operand does not contribute to STALL.
- **`RF_ARB_FORWARD_EN` undefined:**
  - FWDn_HIT and FWDn_DATA are tied to 0.
  - STALL holds until the counter reaches 0.

## Test plan
- **Reset:** assert RESET_N=0 mid-write with RF_WE=1 -> RF_WE=0 asynchronously, all counters 0, STALL=0 after release.
- **Contention:** REQ0 writes (r3, 0xA), REQ1 writes (r4, 0xB), both held VALID from reset -> REQ0 granted first, RF sees r3=0xA then r4=0xB on consecutive cycles.
- **Register 0:** REQ0 writes (r0, 0xFFFF) -> REQ0_READY=1, RF_WE stays 0. ISSUE to r0 -> ISSUE_READY=1, and CHECK_A1=0 -> STALL=0.
- **Hazard:** issue r5 three times -> fourth issue gives ISSUE_READY=0. Write r5 -> counter 2, ISSUE_READY=1. CHECK_A2=5 -> STALL=1 until all three writes commit, and STALL=0 the cycle after the third RF_WE.
- **Same-cycle increment/decrement:** issue r7 in the same cycle RF_WE commits r7 with counter 1 -> counter stays 1, STALL remains 1 for CHECK_A1=7.
- **Forwarding** (`RF_ARB_FORWARD_EN` defined): one outstanding write to r9 = 0x1234, CHECK_A1=9 during the RF_WE cycle -> FWD1_HIT=1, FWD1_DATA=0x1234, STALL=0. Without the macro -> STALL=1 in that cycle.
